exec_issue_unit: RTL and testbench
==================================

EXEC_ISSUE_UNIT -- requirements
Module: exec_issue_unit

Interface
REQ-001 Parameter: DATA_W, 4, operand/result width; only 4 is supported.
REQ-002 Parameter: REG_CNT, 4, register-file depth; register address width is 2.
REQ-003 Port: clk  input  1  single clock; all state changes on the rising edge.
REQ-004 Port: rst_n  input  1  reset, asynchronous and active-low.
REQ-005 Port: in_valid  input  1  an instruction is presented.
REQ-006 Port: in_ready  output  1  unit can accept an instruction this cycle.
REQ-007 Port: in_op  input  3  operation select, forwarded to the execute stage as its sel.
REQ-008 Port: in_rs_addr / in_rt_addr / in_rd_addr  input  2 each  source and destination register indices.
REQ-009 Port: in_load  input  1  load-immediate instruction (bypasses the execute stage).
REQ-010 Port: in_imm  input  4  immediate data for a load.
REQ-011 Port: ex_rs / ex_rt  output  4 each  registered operands to the execute stage.
REQ-012 Port: ex_sel  output  3  registered operation select to the execute stage.
REQ-013 Port: ex_valid  output  1  operands are valid and ex_rd is sampled this cycle.
REQ-014 Port: ex_rd  input  4  combinational result returned by the execute stage.
REQ-015 Port: wb_valid  output  1  one-cycle pulse marking a register write.
REQ-016 Port: wb_addr / wb_data  output  2 / 4  index and value of the last write.
REQ-017 Port: dbg_addr / dbg_data  input 2 / output 4  combinational register-file read port for the display.

Function
REQ-018 The unit SHALL hold REG_CNT x 4-bit registers, with no hard-wired zero register.
REQ-019 The FSM SHALL have three states: IDLE, EXEC and WB.
REQ-020 in_ready SHALL be 1 only in IDLE with rst_n high.
REQ-021 An instruction SHALL be accepted on a rising edge where in_valid and in_ready are both 1; instruction inputs are ignored at all other times.
REQ-022 An accepted load SHALL write reg[in_rd_addr] <= in_imm on the accept edge.
REQ-023 After an accepted load, wb_valid SHALL be 1 for the next cycle with wb_addr = in_rd_addr and wb_data = in_imm, and the FSM SHALL stay in IDLE.
REQ-024 Loads SHALL sustain one per cycle.
REQ-025 An accepted non-load SHALL register ex_rs = reg[in_rs_addr], ex_rt = reg[in_rt_addr] and ex_sel = in_op, latch in_rd_addr, and move the FSM to EXEC.
REQ-026 Operand reads SHALL return values that include all earlier writes, e.g. a load accepted on the immediately preceding edge.
REQ-027 ex_valid SHALL be 1 exactly for the single EXEC cycle.
REQ-028 On the edge that leaves EXEC, the unit SHALL write reg[rd] <= ex_rd and go to WB.
REQ-029 In WB, wb_valid SHALL be 1 with wb_addr = rd and wb_data = the written value; WB SHALL go to IDLE on the next edge.
REQ-030 ALU-op throughput SHALL be one instruction per 3 cycles: accept, EXEC, WB.
REQ-031 A new instruction SHALL be accepted no earlier than the edge that leaves WB+1, i.e. while back in IDLE.
REQ-032 rs_addr = rt_addr and rd_addr equal to a source SHALL be legal; the old value is used as the operand and the result overwrites it.
REQ-033 ex_rs, ex_rt and ex_sel SHALL hold their last values outside EXEC.
REQ-034 wb_addr and wb_data SHALL hold their values when wb_valid is 0.
REQ-035 Result width SHALL be 4 bits, truncated by the execute stage; the unit performs no arithmetic itself.
REQ-036 dbg_data SHALL equal reg[dbg_addr] combinationally and reflect a write from the cycle after the write edge.

Reset
REQ-037 While rst_n is 0, all registers, ex_rs, ex_rt, ex_sel, wb_addr and wb_data SHALL be 0; ex_valid, wb_valid and in_ready SHALL be 0; the FSM SHALL be in IDLE.
REQ-038 Reset asserted in EXEC or WB SHALL abort the instruction with no register write and no wb_valid pulse.
REQ-039 in_ready SHALL be 1 in the first cycle after rst_n deasserts.

Verification
REQ-040 Load R1=5 and R2=3 back-to-back, then op 000 rs=R1 rt=R2 rd=R3 with ex_rd=2 -> ex_rs=5, ex_rt=3, ex_sel=000, ex_valid for 1 cycle; then wb_valid, wb_addr=3, wb_data=2; dbg_addr=3 reads 2.
REQ-041 Load R0=F and R1=1, op 001 rd=R0 with ex_rd=0 -> R0=0; a following op reading R0 sees ex_rs=0.
REQ-042 Hold in_valid high across an ALU op -> in_ready=0 in EXEC and WB; the next instruction is accepted exactly 3 cycles after the first.
REQ-043 Op with rs=rt=rd=R2 (R2=6) -> ex_rs=ex_rt=6; R2 takes the ex_rd value after WB.
REQ-044 Deassert rst_n during EXEC -> no wb_valid pulse, all registers 0, in_ready=1 one cycle after release.
REQ-045 Four back-to-back loads to R0..R3 -> four consecutive wb_valid pulses; dbg_data matches each register.

Source files
------------

// File: rtl/exec_issue_unit.sv
// Register-file issue unit: loads commit in 1 cycle (1/cycle); ALU ops go accept->EXEC->WB (1 per 3 cycles).
// Backpressure: in_ready drops while an ALU op is in EXEC or WB; inputs are ignored then.
module exec_issue_unit #(
   parameter  int DATA_W  = 4,
   parameter  int REG_CNT = 4,
   localparam int AW      = $clog2(REG_CNT)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [2:0]        in_op,
   input  logic [AW-1:0]     in_rs_addr,
   input  logic [AW-1:0]     in_rt_addr,
   input  logic [AW-1:0]     in_rd_addr,
   input  logic              in_load,
   input  logic [DATA_W-1:0] in_imm,
   output logic [DATA_W-1:0] ex_rs,
   output logic [DATA_W-1:0] ex_rt,
   output logic [2:0]        ex_sel,
   output logic              ex_valid,
   input  logic [DATA_W-1:0] ex_rd,
   output logic              wb_valid,
   output logic [AW-1:0]     wb_addr,
   output logic [DATA_W-1:0] wb_data,
   input  logic [AW-1:0]     dbg_addr,
   output logic [DATA_W-1:0] dbg_data
);

   typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

   state_t              state;
   logic [DATA_W-1:0]   rf [REG_CNT];
   logic [AW-1:0]       rd_q;

   assign in_ready = (state == IDLE) && rst_n;
   assign ex_valid = (state == EXEC);
   assign dbg_data = rf[dbg_addr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         for (int i = 0; i < REG_CNT; i++) rf[i] <= '0;
         rd_q     <= '0;
         ex_rs    <= '0;
         ex_rt    <= '0;
         ex_sel   <= '0;
         wb_valid <= 1'b0;
         wb_addr  <= '0;
         wb_data  <= '0;
      end else begin
         wb_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (in_valid) begin
                  if (in_load) begin
                     rf[in_rd_addr] <= in_imm;
                     wb_valid       <= 1'b1;
                     wb_addr        <= in_rd_addr;
                     wb_data        <= in_imm;
                  end else begin
                     // Reads see the previous edge's write because rf is already updated.
                     ex_rs  <= rf[in_rs_addr];
                     ex_rt  <= rf[in_rt_addr];
                     ex_sel <= in_op;
                     rd_q   <= in_rd_addr;
                     state  <= EXEC;
                  end
               end
            end
            EXEC: begin
               rf[rd_q] <= ex_rd;
               wb_valid <= 1'b1;
               wb_addr  <= rd_q;
               wb_data  <= ex_rd;
               state    <= WB;
            end
            WB: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_exec_issue_unit.sv
// Bench for exec_issue_unit: vector table of instructions plus hand-written hold/back-to-back/reset-abort sequences.
module tb_exec_issue_unit;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid, in_ready, in_load, ex_valid, wb_valid;
   logic [2:0] in_op, ex_sel;
   logic [1:0] in_rs_addr, in_rt_addr, in_rd_addr, wb_addr, dbg_addr;
   logic [3:0] in_imm, ex_rs, ex_rt, ex_rd, wb_data, dbg_data;

   exec_issue_unit #(.DATA_W(4), .REG_CNT(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
      .in_rs_addr(in_rs_addr), .in_rt_addr(in_rt_addr), .in_rd_addr(in_rd_addr),
      .in_load(in_load), .in_imm(in_imm),
      .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_sel(ex_sel), .ex_valid(ex_valid), .ex_rd(ex_rd),
      .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
      .dbg_addr(dbg_addr), .dbg_data(dbg_data)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      bit         load;
      logic [2:0] op;
      logic [1:0] rs, rt, rd;
      logic [3:0] imm, exrd, e_rs, e_rt;
   } vec_t;
   typedef struct packed { logic [3:0] rs, rt; logic [2:0] sel; } ex_exp_t;
   typedef struct packed { logic [1:0] addr; logic [3:0] data; } wb_exp_t;

   ex_exp_t    exq[$];
   wb_exp_t    wbq[$];
   logic [3:0] model [4];
   vec_t       tbl [10];
   int         compared = 0, mismatched = 0, cyc = 0;
   int         t0, t1;

   always @(posedge clk) cyc++;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard: every ex_valid / wb_valid cycle must match the oldest pending expectation.
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         if (ex_valid) begin
            if (exq.size() == 0) chk("stray_ex_valid", 1, 0);
            else begin
               ex_exp_t e;
               e = exq.pop_front();
               chk("ex_rs", ex_rs, e.rs);
               chk("ex_rt", ex_rt, e.rt);
               chk("ex_sel", ex_sel, e.sel);
            end
         end
         if (wb_valid) begin
            if (wbq.size() == 0) chk("stray_wb_valid", 1, 0);
            else begin
               wb_exp_t w;
               w = wbq.pop_front();
               chk("wb_addr", wb_addr, w.addr);
               chk("wb_data", wb_data, w.data);
            end
         end
      end
   end

   task automatic sync();
      @(posedge clk); #1;
   endtask

   task automatic check_dbg(input int a);
      dbg_addr = a[1:0]; #1;
      chk($sformatf("dbg_r%0d", a), dbg_data, model[a]);
   endtask

   // Call right after posedge+1; returns at posedge+1 after the accept edge.
   task automatic issue(input vec_t v, input bit want_wb);
      bit got;
      in_valid = 1'b1; in_load = v.load; in_op = v.op;
      in_rs_addr = v.rs; in_rt_addr = v.rt; in_rd_addr = v.rd; in_imm = v.imm;
      if (!v.load) begin
         ex_rd = v.exrd;
         exq.push_back('{v.e_rs, v.e_rt, v.op});
      end
      if (want_wb) begin
         wbq.push_back('{v.rd, v.load ? v.imm : v.exrd});
         model[v.rd] = v.load ? v.imm : v.exrd;
      end
      got = 1'b0;
      for (int c = 0; c < 20 && !got; c++) begin
         @(negedge clk);
         if (in_ready) got = 1'b1;
         @(posedge clk);
      end
      #1;
      in_valid = 1'b0;
      t1 = cyc;
      if (!got) chk("accept_timeout", 0, 1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      //           load op    rs    rt    rd    imm   exrd  e_rs  e_rt
      tbl[0] = '{1'b1, 3'd0, 2'd0, 2'd0, 2'd1, 4'h5, 4'h0, 4'h0, 4'h0};
      tbl[1] = '{1'b1, 3'd0, 2'd0, 2'd0, 2'd2, 4'h3, 4'h0, 4'h0, 4'h0};
      tbl[2] = '{1'b0, 3'd0, 2'd1, 2'd2, 2'd3, 4'h0, 4'h2, 4'h5, 4'h3};
      tbl[3] = '{1'b1, 3'd0, 2'd0, 2'd0, 2'd0, 4'hF, 4'h0, 4'h0, 4'h0};
      tbl[4] = '{1'b1, 3'd0, 2'd0, 2'd0, 2'd1, 4'h1, 4'h0, 4'h0, 4'h0};
      tbl[5] = '{1'b0, 3'd1, 2'd1, 2'd0, 2'd0, 4'h0, 4'h0, 4'h1, 4'hF};
      tbl[6] = '{1'b0, 3'd2, 2'd0, 2'd3, 2'd1, 4'h0, 4'h7, 4'h0, 4'h2};
      tbl[7] = '{1'b1, 3'd0, 2'd0, 2'd0, 2'd2, 4'h6, 4'h0, 4'h0, 4'h0};
      tbl[8] = '{1'b0, 3'd3, 2'd2, 2'd2, 2'd2, 4'h0, 4'h9, 4'h6, 4'h6};
      tbl[9] = '{1'b0, 3'd4, 2'd2, 2'd1, 2'd3, 4'h0, 4'hA, 4'h9, 4'h7};

      for (int i = 0; i < 4; i++) model[i] = 4'h0;
      rst_n = 1'b0; in_valid = 1'b0; in_load = 1'b0; in_op = '0;
      in_rs_addr = '0; in_rt_addr = '0; in_rd_addr = '0; in_imm = '0;
      ex_rd = '0; dbg_addr = '0;

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_ex_valid", ex_valid, 0);
      chk("rst_wb_valid", wb_valid, 0);
      chk("rst_ex_rs", ex_rs, 0);
      chk("rst_ex_sel", ex_sel, 0);
      chk("rst_wb_data", wb_data, 0);
      for (int a = 0; a < 4; a++) check_dbg(a);
      rst_n = 1'b1;
      @(posedge clk); @(negedge clk);
      chk("in_ready_after_rst", in_ready, 1);
      sync();

      // Instruction table
      for (int i = 0; i < 10; i++) begin
         issue(tbl[i], 1'b1);
         if (!tbl[i].load) begin
            @(posedge clk); @(negedge clk);
            check_dbg(int'(tbl[i].rd));
            sync();
         end
      end
      @(negedge clk);
      for (int a = 0; a < 4; a++) check_dbg(a);
      sync();

      // in_valid held high across an ALU op; follow-on load accepted 3 cycles later
      in_valid = 1'b1; in_load = 1'b0; in_op = 3'd5;
      in_rs_addr = 2'd3; in_rt_addr = 2'd1; in_rd_addr = 2'd0; ex_rd = 4'h4;
      exq.push_back('{4'hA, 4'h7, 3'd5});
      wbq.push_back('{2'd0, 4'h4}); model[0] = 4'h4;
      @(negedge clk); chk("hold_ready_idle", in_ready, 1);
      @(posedge clk); #1;
      t0 = cyc;
      in_load = 1'b1; in_rd_addr = 2'd1; in_imm = 4'hC;
      wbq.push_back('{2'd1, 4'hC}); model[1] = 4'hC;
      @(negedge clk); chk("hold_ready_exec", in_ready, 0);
      @(posedge clk); @(negedge clk); chk("hold_ready_wb", in_ready, 0);
      @(posedge clk); @(negedge clk); chk("hold_ready_back", in_ready, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("hold_accept_gap", cyc - t0, 3);
      @(negedge clk);
      check_dbg(0); check_dbg(1);
      sync();

      // Four back-to-back loads
      for (int i = 0; i < 4; i++) begin
         vec_t v;
         v = '{1'b1, 3'd0, 2'd0, 2'd0, i[1:0], 4'(i + 1), 4'h0, 4'h0, 4'h0};
         issue(v, 1'b1);
         if (i == 0) t0 = t1;
      end
      chk("load_burst_cycles", t1 - t0, 3);
      @(negedge clk);
      for (int a = 0; a < 4; a++) check_dbg(a);
      sync();

      // Reset during EXEC aborts the op
      issue('{1'b0, 3'd6, 2'd0, 2'd1, 2'd2, 4'h0, 4'hF, 4'h1, 4'h2}, 1'b0);
      @(negedge clk); #2;
      rst_n = 1'b0;
      for (int i = 0; i < 4; i++) model[i] = 4'h0;
      @(posedge clk); @(negedge clk);
      chk("abort_in_ready", in_ready, 0);
      chk("abort_ex_valid", ex_valid, 0);
      chk("abort_wb_valid", wb_valid, 0);
      chk("abort_ex_rt", ex_rt, 0);
      chk("abort_wb_addr", wb_addr, 0);
      for (int a = 0; a < 4; a++) check_dbg(a);
      #1 rst_n = 1'b1;
      @(posedge clk); @(negedge clk);
      chk("abort_ready_after", in_ready, 1);
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("abort_no_wb", wb_valid, 0);
      chk("exq_drained", exq.size(), 0);
      chk("wbq_drained", wbq.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
